// File: rtl/iir_wishbone_pkg.sv
// Shared constants for the Wishbone biquad: register byte addresses, control/status bit
// positions, coefficient slot order and the unity reset coefficient.
package iir_wishbone_pkg;

   localparam int unsigned ADDR_Y      = 'h00;
   localparam int unsigned ADDR_B0     = 'h04;
   localparam int unsigned ADDR_B1     = 'h08;
   localparam int unsigned ADDR_B2     = 'h0C;
   localparam int unsigned ADDR_A1     = 'h10;
   localparam int unsigned ADDR_A2     = 'h14;
   localparam int unsigned ADDR_CTRL   = 'h18;
   localparam int unsigned ADDR_STATUS = 'h1C;
   localparam int unsigned ADDR_X      = 'h3C;

   localparam int CTRL_CLEAR_BIT  = 0;
   localparam int STATUS_BUSY_BIT = 0;

   // Coefficient slots line up with the core's operands: x, x1, x2, y1, y2
   localparam int COEF_B0  = 0;
   localparam int COEF_B1  = 1;
   localparam int COEF_B2  = 2;
   localparam int COEF_A1  = 3;
   localparam int COEF_A2  = 4;
   localparam int NUM_COEF = 5;

   typedef enum logic [3:0] {
      SEL_NONE,
      SEL_Y,
      SEL_B0,
      SEL_B1,
      SEL_B2,
      SEL_A1,
      SEL_A2,
      SEL_CTRL,
      SEL_STATUS,
      SEL_X
   } reg_sel_e;

   function automatic logic [63:0] unity_coef(input int frac);
      return 64'd1 << frac;
   endfunction

   function automatic reg_sel_e reg_decode(input int unsigned byte_addr);
      case (byte_addr)
         ADDR_Y:      return SEL_Y;
         ADDR_B0:     return SEL_B0;
         ADDR_B1:     return SEL_B1;
         ADDR_B2:     return SEL_B2;
         ADDR_A1:     return SEL_A1;
         ADDR_A2:     return SEL_A2;
         ADDR_CTRL:   return SEL_CTRL;
         ADDR_STATUS: return SEL_STATUS;
         ADDR_X:      return SEL_X;
         default:     return SEL_NONE;
      endcase
   endfunction

   function automatic reg_sel_e coef_sel(input int idx);
      case (idx)
         COEF_B0: return SEL_B0;
         COEF_B1: return SEL_B1;
         COEF_B2: return SEL_B2;
         COEF_A1: return SEL_A1;
         COEF_A2: return SEL_A2;
         default: return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/iir_wishbone_biquad_core.sv
// Direct-form-I biquad MAC pipeline with its own history. Output saturates when
// IIR_WISHBONE_SATURATE_EN is defined, otherwise it wraps to DATA_WIDTH bits.
module iir_biquad_core
   import iir_wishbone_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int COEF_FRAC  = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic                         i_clear,
   input  logic signed [DATA_WIDTH-1:0] i_x,
   input  logic signed [DATA_WIDTH-1:0] i_coef [NUM_COEF],
   output logic signed [DATA_WIDTH-1:0] o_y,
   output logic                         o_busy
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = PW + 3;

   logic                         r_v1;
   logic                         r_v2;
   logic signed [DATA_WIDTH-1:0] r_xs;
   logic signed [DATA_WIDTH-1:0] r_xm1;
   logic signed [DATA_WIDTH-1:0] r_xm2;
   logic signed [DATA_WIDTH-1:0] r_ym1;
   logic signed [DATA_WIDTH-1:0] r_ym2;
   logic signed [DATA_WIDTH-1:0] r_y;
   logic signed [DATA_WIDTH-1:0] r_coef [NUM_COEF];
   logic signed [PW-1:0]         r_prod [NUM_COEF];

   logic signed [DATA_WIDTH-1:0] w_opnd [NUM_COEF];
   logic signed [PW-1:0]         w_prod [NUM_COEF];
   logic signed [AW-1:0]         w_acc;
   logic signed [AW-1:0]         w_shift;
   logic signed [DATA_WIDTH-1:0] w_ynew;

   assign w_opnd[COEF_B0] = r_xs;
   assign w_opnd[COEF_B1] = r_xm1;
   assign w_opnd[COEF_B2] = r_xm2;
   assign w_opnd[COEF_A1] = r_ym1;
   assign w_opnd[COEF_A2] = r_ym2;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_COEF; gi++) begin : g_mul
         assign w_prod[gi] = PW'(w_opnd[gi]) * PW'(r_coef[gi]);
      end
   endgenerate

   assign w_acc = AW'(r_prod[COEF_B0]) + AW'(r_prod[COEF_B1]) + AW'(r_prod[COEF_B2])
                - AW'(r_prod[COEF_A1]) - AW'(r_prod[COEF_A2]);
   assign w_shift = w_acc >>> COEF_FRAC;

`ifdef IIR_WISHBONE_SATURATE_EN
   localparam logic signed [AW-1:0] SAT_MAX = AW'((AW'(1) << (DATA_WIDTH - 1)) - AW'(1));
   localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - 1;

   always_comb begin
      w_ynew = w_shift[DATA_WIDTH-1:0];
      if (w_shift > SAT_MAX) begin
         w_ynew = SAT_MAX[DATA_WIDTH-1:0];
      end else if (w_shift < SAT_MIN) begin
         w_ynew = SAT_MIN[DATA_WIDTH-1:0];
      end
   end
`else
   assign w_ynew = w_shift[DATA_WIDTH-1:0];
`endif

   // Operand x and coefficients are snapshotted at start so bus writes never disturb a step
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_xs  <= '0;
         r_xm1 <= '0;
         r_xm2 <= '0;
         r_ym1 <= '0;
         r_ym2 <= '0;
         r_y   <= '0;
         for (int k = 0; k < NUM_COEF; k++) begin
            r_coef[k] <= '0;
            r_prod[k] <= '0;
         end
      end else begin
         r_v1 <= i_start;
         r_v2 <= r_v1;
         if (i_start) begin
            r_xs <= i_x;
            for (int k = 0; k < NUM_COEF; k++) begin
               r_coef[k] <= i_coef[k];
            end
         end
         if (r_v1) begin
            for (int k = 0; k < NUM_COEF; k++) begin
               r_prod[k] <= w_prod[k];
            end
         end
         if (i_clear) begin
            r_xm1 <= '0;
            r_xm2 <= '0;
            r_ym1 <= '0;
            r_ym2 <= '0;
            r_y   <= '0;
         end else if (r_v2) begin
            r_xm2 <= r_xm1;
            r_xm1 <= r_xs;
            r_ym2 <= r_ym1;
            r_ym1 <= w_ynew;
            r_y   <= w_ynew;
         end
      end
   end

   assign o_y    = r_y;
   assign o_busy = r_v1 | r_v2;

endmodule

// File: rtl/iir_wishbone.sv
// Wishbone slave wrapping the biquad core: bus decode, coefficient/X registers, readback.
// Build option IIR_WISHBONE_SATURATE_EN selects saturating output (default: wrap).
module iir_wishbone
   import iir_wishbone_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int COEF_FRAC  = 16
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   input  logic                  wb_we_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_cyc_i,
   output logic                  wb_ack_o
);

   localparam logic [DATA_WIDTH-1:0] COEF_ONE = DATA_WIDTH'(unity_coef(COEF_FRAC));

   logic                         r_ack;
   logic [DATA_WIDTH-1:0]        r_dat;
   logic [DATA_WIDTH-1:0]        r_x;
   logic signed [DATA_WIDTH-1:0] r_coef [NUM_COEF];

   logic                         w_req;
   logic                         w_wr;
   logic                         w_rd;
   logic                         w_busy;
   logic                         w_start;
   logic                         w_clear;
   reg_sel_e                     w_sel;
   logic [DATA_WIDTH-1:0]        w_rdata;
   logic signed [DATA_WIDTH-1:0] w_y;
   logic [NUM_COEF-1:0]          w_coef_we;

   // Requests are only taken while ack is low, so every access is acked exactly once
   assign w_req   = wb_stb_i & wb_cyc_i & ~r_ack;
   assign w_wr    = w_req & wb_we_i;
   assign w_rd    = w_req & ~wb_we_i;
   assign w_sel   = reg_decode(int'(wb_adr_i));
   assign w_start = w_wr && (w_sel == SEL_X) && !w_busy;
   assign w_clear = w_wr && (w_sel == SEL_CTRL) && wb_dat_i[CTRL_CLEAR_BIT];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_COEF; gi++) begin : g_coef_we
         assign w_coef_we[gi] = w_wr && (w_sel == coef_sel(gi));
      end
   endgenerate

   always_comb begin
      w_rdata = '0;
      case (w_sel)
         SEL_Y:      w_rdata = w_y;
         SEL_B0:     w_rdata = r_coef[COEF_B0];
         SEL_B1:     w_rdata = r_coef[COEF_B1];
         SEL_B2:     w_rdata = r_coef[COEF_B2];
         SEL_A1:     w_rdata = r_coef[COEF_A1];
         SEL_A2:     w_rdata = r_coef[COEF_A2];
         SEL_STATUS: w_rdata[STATUS_BUSY_BIT] = w_busy;
         SEL_X:      w_rdata = r_x;
         default:    w_rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
         r_x   <= '0;
         for (int k = 0; k < NUM_COEF; k++) begin
            r_coef[k] <= (k == COEF_B0) ? COEF_ONE : '0;
         end
      end else begin
         r_ack <= w_req;
         if (w_rd) begin
            r_dat <= w_rdata;
         end
         if (w_start) begin
            r_x <= wb_dat_i;
         end
         for (int k = 0; k < NUM_COEF; k++) begin
            if (w_coef_we[k]) begin
               r_coef[k] <= wb_dat_i;
            end
         end
      end
   end

   iir_biquad_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_FRAC  (COEF_FRAC)
   ) u_core (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_start (w_start),
      .i_clear (w_clear),
      .i_x     (wb_dat_i),
      .i_coef  (r_coef),
      .o_y     (w_y),
      .o_busy  (w_busy)
   );

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_iir_wishbone.sv
// Directed bench for iir_wishbone: vector table of bus accesses with hand-computed
// expectations, plus hand-written sequences for strobe hold, busy drop and mid-step reset.
module tb_iir_wishbone;

   localparam int OP_WR  = 0;
   localparam int OP_WX  = 1;
   localparam int OP_RD  = 2;
   localparam int OP_RST = 3;

`ifdef IIR_WISHBONE_SATURATE_EN
   localparam logic [31:0] BIG_EXP = 32'h7FFF_FFFF;
`else
   localparam logic [31:0] BIG_EXP = 32'hFFFF_FFFE;
`endif

   typedef struct {
      int          op;
      logic [7:0]  adr;
      logic [31:0] dat;
      logic [31:0] exp;
      string       name;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  adr = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic        we = 1'b0;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        ack;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   iir_wishbone dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_adr_i (adr),
      .wb_dat_i (dat_i),
      .wb_dat_o (dat_o),
      .wb_we_i  (we),
      .wb_stb_i (stb),
      .wb_cyc_i (cyc),
      .wb_ack_o (ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] q);
      int n;
      @(posedge clk);
      #1;
      we = w; adr = a[5:0]; dat_i = d; stb = 1'b1; cyc = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack && n < 8);
      if (!ack) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ack_timeout: no ack at adr 0x%02h after %0d cycles", a, n);
      end
      q = dat_o;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic add(input int op, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] e, input string name);
      vec_t v;
      v.op = op; v.adr = a; v.dat = d; v.exp = e; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic rd_check(input logic [7:0] a, input logic [31:0] e, input string name);
      logic [31:0] q;
      bus(1'b0, a, 32'h0, q);
      check(name, q, e);
   endtask

   initial begin
      logic [31:0] q;
      int acks;

      // reset state and pass-through
      add(OP_RD,  8'h00, 0, 32'h0,         "rst_y");
      add(OP_RD,  8'h04, 0, 32'h0001_0000, "rst_b0");
      add(OP_RD,  8'h08, 0, 32'h0,         "rst_b1");
      add(OP_RD,  8'h10, 0, 32'h0,         "rst_a1");
      add(OP_RD,  8'h3C, 0, 32'h0,         "rst_x");
      add(OP_RD,  8'h1C, 0, 32'h0,         "rst_status");
      add(OP_WX,  8'h3C, 100, 0,           "");
      add(OP_RD,  8'h40, 0, 32'd100,       "pass_100");
      add(OP_WX,  8'h3C, -7, 0,            "");
      add(OP_RD,  8'h40, 0, -7,            "pass_m7");
      add(OP_RD,  8'h3C, 0, -7,            "x_readback");
      // two-tap average
      add(OP_RST, 0, 0, 0, "");
      add(OP_WR,  8'h04, 32'h8000, 0, "");
      add(OP_WR,  8'h08, 32'h8000, 0, "");
      add(OP_WX,  8'h3C, 100, 0, "");
      add(OP_RD,  8'h00, 0, 32'd50,        "avg_50");
      add(OP_WX,  8'h3C, 200, 0, "");
      add(OP_RD,  8'h00, 0, 32'd150,       "avg_150");
      add(OP_RD,  8'h08, 0, 32'h8000,      "b1_readback");
      // one-pole feedback and clear
      add(OP_RST, 0, 0, 0, "");
      add(OP_WR,  8'h10, 32'hFFFF_8000, 0, "");
      add(OP_WX,  8'h3C, 1000, 0, "");
      add(OP_RD,  8'h00, 0, 32'd1000,      "fb_1000");
      add(OP_WX,  8'h3C, 0, 0, "");
      add(OP_RD,  8'h00, 0, 32'd500,       "fb_500");
      add(OP_WX,  8'h3C, 0, 0, "");
      add(OP_RD,  8'h00, 0, 32'd250,       "fb_250");
      add(OP_WR,  8'h18, 32'h1, 0, "");
      add(OP_RD,  8'h18, 0, 32'h0,         "ctrl_reads0");
      add(OP_RD,  8'h00, 0, 32'h0,         "clear_y");
      add(OP_WX,  8'h3C, 0, 0, "");
      add(OP_RD,  8'h00, 0, 32'h0,         "clear_hist");
      // overflow
      add(OP_RST, 0, 0, 0, "");
      add(OP_WR,  8'h04, 32'h2_0000, 0, "");
      add(OP_WX,  8'h3C, 32'h7FFF_FFFF, 0, "");
      add(OP_RD,  8'h00, 0, BIG_EXP,       "overflow");
      // floor shift, unmapped and RO accesses, remaining coefficient slots
      add(OP_RST, 0, 0, 0, "");
      add(OP_WR,  8'h04, 32'h8000, 0, "");
      add(OP_WX,  8'h3C, -3, 0, "");
      add(OP_RD,  8'h00, 0, -2,            "floor_m1p5");
      add(OP_WR,  8'h00, 32'h99, 0, "");
      add(OP_RD,  8'h00, 0, -2,            "y_readonly");
      add(OP_WR,  8'h30, 32'h1234, 0, "");
      add(OP_RD,  8'h30, 0, 32'h0,         "unmapped_rd");
      add(OP_WR,  8'h0C, 32'hABC, 0, "");
      add(OP_RD,  8'h0C, 0, 32'hABC,       "b2_readback");
      add(OP_WR,  8'h14, 32'h55, 0, "");
      add(OP_RD,  8'h14, 0, 32'h55,        "a2_readback");

      do_reset();
      #1;
      check("rst_ack", {31'b0, ack}, 32'h0);
      check("rst_dat_o", dat_o, 32'h0);

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_WR:  bus(1'b1, vecs[i].adr, vecs[i].dat, q);
            OP_WX:  begin
               bus(1'b1, vecs[i].adr, vecs[i].dat, q);
               repeat (3) @(posedge clk);
            end
            OP_RD:  rd_check(vecs[i].adr, vecs[i].exp, vecs[i].name);
            default: do_reset();
         endcase
      end

      // strobe held two cycles on an X write: one ack, one step
      do_reset();
      bus(1'b1, 8'h08, 32'h1_0000, q);
      @(posedge clk);
      #1;
      we = 1'b1; adr = 6'h3C; dat_i = 32'd5; stb = 1'b1; cyc = 1'b1;
      acks = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (ack) acks++;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (ack) acks++;
      end
      check("hold_ack_count", acks, 1);
      rd_check(8'h00, 32'd5, "hold_y");

      // X write during BUSY is dropped; STATUS shows BUSY mid-step
      bus(1'b1, 8'h3C, 32'd7, q);
      bus(1'b1, 8'h3C, 32'd9, q);
      repeat (3) @(posedge clk);
      rd_check(8'h3C, 32'd7, "busy_x_kept");
      rd_check(8'h00, 32'd12, "busy_y");
      bus(1'b1, 8'h3C, 32'd2, q);
      rd_check(8'h1C, 32'h1, "status_busy");
      repeat (3) @(posedge clk);
      rd_check(8'h00, 32'd9, "busy_hist");
      rd_check(8'h1C, 32'h0, "status_idle");

      // reset at E+1 aborts the step
      do_reset();
      bus(1'b1, 8'h04, 32'h2_0000, q);
      @(posedge clk);
      #1;
      we = 1'b1; adr = 6'h3C; dat_i = 32'd3; stb = 1'b1; cyc = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ack_e", {31'b0, ack}, 32'h1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_ack_low", {31'b0, ack}, 32'h0);
      repeat (3) @(posedge clk);
      rd_check(8'h00, 32'h0, "midrst_y");
      rd_check(8'h04, 32'h1_0000, "midrst_b0");
      rd_check(8'h3C, 32'h0, "midrst_x");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/iir_wishbone.md
IIR_WISHBONE -- requirements
Module: iir_wishbone

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data and sample width (signed two's complement).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, byte address width.
REQ-003 SHALL have parameter COEF_FRAC, default 16, fractional bits of coefficients (Q15.16 at default).
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port wb_adr_i, input, ADDR_WIDTH, byte address.
REQ-007 SHALL have port wb_dat_i, input, DATA_WIDTH, write data.
REQ-008 SHALL have port wb_dat_o, output, DATA_WIDTH, registered read data.
REQ-009 SHALL have ports wb_we_i, wb_stb_i and wb_cyc_i, each input, 1: write enable, strobe, cycle.
REQ-010 SHALL have port wb_ack_o, output, 1, registered acknowledge.

Function
REQ-011 Register map (byte address):
- 0x00 Y, RO, last output; addresses wrap mod 2^ADDR_WIDTH, so 0x40 aliases here.
- 0x04 B0, 0x08 B1, 0x0C B2, 0x10 A1, 0x14 A2: RW, signed Q(DATA_WIDTH-COEF_FRAC-1).COEF_FRAC.
- 0x18 CTRL, W: bit0=1 clears history (self-clearing); reads 0.
- 0x1C STATUS, RO: bit0 BUSY.
- 0x3C X, RW: writing starts one filter step; reads return last X.
REQ-012 Ack SHALL be 1 on the edge after wb_stb_i&wb_cyc_i&!wb_ack_o, for exactly one cycle, then 0 for at least one cycle even if strobe stays high.
REQ-013 Writes SHALL take effect only on the acking edge, so a strobe held one extra cycle does not repeat the write.
REQ-014 wb_dat_o SHALL load on the acking edge of a read and hold until the next read ack.
REQ-015 Accesses to unmapped addresses SHALL be acked: reads return 0 and writes are ignored.
REQ-016 Filter SHALL be a direct-form-I biquad: y[n] = (B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2]) >>> COEF_FRAC.
REQ-017 Products SHALL be full 2*DATA_WIDTH signed and summed in an accumulator of at least 2*DATA_WIDTH+3 bits; the shift is arithmetic (floor).
REQ-018 Latency: X write ack at edge E; products registered at E+1; Y, x[n-1], x[n-2], y[n-1] and y[n-2] updated at E+2; BUSY high from E through E+1.
REQ-019 An X write while BUSY SHALL be acked and dropped.
REQ-020 Coefficient writes SHALL apply from the next X write; an in-flight step uses the old values.
REQ-021 A CTRL clear SHALL zero the history and Y in the cycle it is acked; a clear coinciding with E+2 wins.

Reset
REQ-022 On reset the following SHALL be 0: wb_ack_o, wb_dat_o, Y, X, history, BUSY, the pipeline, A1, A2, B1 and B2.
REQ-023 On reset B0 SHALL be 1<<COEF_FRAC (unity pass-through).
REQ-024 Reset mid-step SHALL abort the step with no Y update.

Configuration
REQ-025 Macro IIR_WISHBONE_SATURATE_EN defined:
- the shifted sum SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before storing to Y and y history.
REQ-026 Macro IIR_WISHBONE_SATURATE_EN undefined:
- the shifted sum SHALL be truncated to DATA_WIDTH bits (wrap).

Structure
REQ-027 Package iir_wishbone_pkg SHALL hold the register address constants, the CTRL/STATUS bit indices and the reset coefficient value.
REQ-028 Sub-module iir_biquad_core SHALL hold the coefficient-independent MAC pipeline and history; iir_wishbone holds the bus decode and registers.

Verification
REQ-029 After reset, write 100 to 0x3C, wait 2 cycles, read 0x40 -> 100; then write -7 -> -7.
REQ-030 Set B0=0x8000 and B1=0x8000, write inputs 100 then 200 -> Y reads 50 then 150.
REQ-031 Set B0=0x10000 and A1=0xFFFF8000 (-0.5), write inputs 1000, 0, 0 -> Y = 1000, 500, 250; write CTRL=1, then input 0 -> Y = 0.
REQ-032 Set B0=0x20000, write input 0x7FFFFFFF -> Y = 0x7FFFFFFF with the macro, 0xFFFFFFFE without.
REQ-033 Hold strobe 2 cycles on an X write -> exactly one ack and one step; an X write during BUSY -> acked and ignored; a read of 0x30 -> 0.
REQ-034 Assert reset at E+1 of a step -> Y=0 and B0 reads 0x10000.
